t07_fpu_mult: RTL and testbench

//   Iterative IEEE-754 single-precision multiplier, companion to the FPU divider
//   in the team_07 FPU. It handles the FMUL.S side of the datapath.
//   The FPU control FSM pulses start with two operands and waits for done.
//   The block unpacks the operands, runs a 24-step shift-add mantissa multiply,

---
 rtl/t07_fpu_mult.sv | 236 +++++++++++++++++++++++
 tb/tb_t07_fpu_mult.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/t07_fpu_mult.sv
// Iterative IEEE-754 single-precision multiplier: unpack, 24-step shift-add
// mantissa multiply, normalise, round-to-nearest-even, pack.
module t07_fpu_mult #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int BIAS   = 127
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      start,
    input  logic [EXP_W+MANT_W-1:0]   inA,
    input  logic [EXP_W+MANT_W-1:0]   inB,
    output logic                      busy,
    output logic                      done,
    output logic [EXP_W+MANT_W-1:0]   result,
    output logic                      sign,
    output logic                      overflow,
    output logic                      underflow,
    output logic                      invalid,
    output logic [2:0]                state_dbg
);
    // Handshake: start is a request sampled only in IDLE while done is low;
    // done is a one-cycle pulse and result/flags stay valid until the next accepted start.
    localparam int W      = EXP_W + MANT_W;
    localparam int FRAC_W = MANT_W - 1;
    localparam int PROD_W = 2 * MANT_W;
    localparam int EA_W   = EXP_W + 2;
    localparam int CNT_W  = $clog2(MANT_W + 1);
    localparam logic [EXP_W-1:0]        EXP_ONES  = {EXP_W{1'b1}};
    localparam logic signed [EA_W-1:0]  EXP_MAX_S = EA_W'(2 ** EXP_W - 1);
    localparam logic signed [EA_W-1:0]  EXP_MIN_S = '0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_MULT   = 3'd2,
        S_NORM   = 3'd3,
        S_ROUND  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                   state_q;
    logic [W-1:0]             a_q, b_q;
    logic [EXP_W-1:0]         ea_q, eb_q;
    logic                     psign_q, nan_q, inf_q, zero_q;
    logic [PROD_W-1:0]        mcand_q, acc_q;
    logic [MANT_W-1:0]        mplier_q;
    logic [CNT_W-1:0]         step_q;
    logic [FRAC_W-1:0]        mant_q;
    logic                     g_q, r_q, s_q;
    logic signed [EA_W-1:0]   exp_q;
    logic [W-1:0]             res_st_q;
    logic                     sgn_st_q, ovf_st_q, unf_st_q, inv_st_q;
    logic                     busy_q, done_q, sign_q, overflow_q, underflow_q, invalid_q;
    logic [W-1:0]             result_q;

    logic [EXP_W-1:0]  a_exp, b_exp;
    logic [FRAC_W-1:0] a_frac, b_frac;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign a_exp  = a_q[W-2 -: EXP_W];
    assign b_exp  = b_q[W-2 -: EXP_W];
    assign a_frac = a_q[FRAC_W-1:0];
    assign b_frac = b_q[FRAC_W-1:0];
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
    assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
    assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
    assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);

    // Normalisation: the product of two [1,2) mantissas lies in [1,4).
    logic [FRAC_W-1:0]       mant_d;
    logic                    g_d, r_d, s_d;
    logic signed [EA_W-1:0]  exp_d;

    always_comb begin
        exp_d = EA_W'({2'b00, ea_q}) + EA_W'({2'b00, eb_q}) - EA_W'(BIAS)
              + EA_W'(acc_q[PROD_W-1]);
        if (acc_q[PROD_W-1]) begin
            mant_d = acc_q[PROD_W-2 -: FRAC_W];
            g_d    = acc_q[MANT_W-1];
            r_d    = acc_q[MANT_W-2];
            s_d    = |acc_q[MANT_W-3:0];
        end else begin
            mant_d = acc_q[PROD_W-3 -: FRAC_W];
            g_d    = acc_q[MANT_W-2];
            r_d    = acc_q[MANT_W-3];
            s_d    = |acc_q[MANT_W-4:0];
        end
    end

    logic                    inc_d, carry_d;
    logic [FRAC_W-1:0]       mant_r_d;
    logic signed [EA_W-1:0]  exp_r_d;
    logic [W-1:0]            res_d;
    logic                    sgn_d, ovf_d, unf_d, inv_d;

    always_comb begin
        inc_d               = g_q & (r_q | s_q | mant_q[0]);
        {carry_d, mant_r_d} = {1'b0, mant_q} + {{FRAC_W{1'b0}}, inc_d};
        exp_r_d             = carry_d ? exp_q + EA_W'(1) : exp_q;
        res_d               = {psign_q, exp_r_d[EXP_W-1:0], mant_r_d};
        sgn_d               = psign_q;
        ovf_d               = 1'b0;
        unf_d               = 1'b0;
        inv_d               = 1'b0;
        if (nan_q) begin
            res_d = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};
            sgn_d = 1'b0;
            inv_d = 1'b1;
        end else if (inf_q) begin
            res_d = {psign_q, EXP_ONES, {FRAC_W{1'b0}}};
        end else if (zero_q) begin
            res_d = {psign_q, {(W-1){1'b0}}};
        end else if (exp_r_d >= EXP_MAX_S) begin
            res_d = {psign_q, EXP_ONES, {FRAC_W{1'b0}}};
            ovf_d = 1'b1;
        end else if (exp_r_d <= EXP_MIN_S) begin
            res_d = {psign_q, {(W-1){1'b0}}};
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            ea_q        <= '0;
            eb_q        <= '0;
            psign_q     <= 1'b0;
            nan_q       <= 1'b0;
            inf_q       <= 1'b0;
            zero_q      <= 1'b0;
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            step_q      <= '0;
            mant_q      <= '0;
            g_q         <= 1'b0;
            r_q         <= 1'b0;
            s_q         <= 1'b0;
            exp_q       <= '0;
            res_st_q    <= '0;
            sgn_st_q    <= 1'b0;
            ovf_st_q    <= 1'b0;
            unf_st_q    <= 1'b0;
            inv_st_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            sign_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            invalid_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // done_q high means this is the pulse cycle, where start is ignored
                    if (start && !done_q) begin
                        a_q         <= inA;
                        b_q         <= inB;
                        busy_q      <= 1'b1;
                        overflow_q  <= 1'b0;
                        underflow_q <= 1'b0;
                        invalid_q   <= 1'b0;
                        state_q     <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    ea_q     <= a_exp;
                    eb_q     <= b_exp;
                    mcand_q  <= PROD_W'({~a_zero, a_frac});
                    mplier_q <= {~b_zero, b_frac};
                    acc_q    <= '0;
                    step_q   <= '0;
                    psign_q  <= a_q[W-1] ^ b_q[W-1];
                    nan_q    <= a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
                    inf_q    <= a_inf | b_inf;
                    zero_q   <= a_zero | b_zero;
                    state_q  <= S_MULT;
                end
                S_MULT: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mplier_q <= mplier_q >> 1;
                    mcand_q  <= mcand_q << 1;
                    step_q   <= step_q + CNT_W'(1);
                    if (step_q == CNT_W'(MANT_W - 1)) begin
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    mant_q  <= mant_d;
                    g_q     <= g_d;
                    r_q     <= r_d;
                    s_q     <= s_d;
                    exp_q   <= exp_d;
                    state_q <= S_ROUND;
                end
                S_ROUND: begin
                    res_st_q <= res_d;
                    sgn_st_q <= sgn_d;
                    ovf_st_q <= ovf_d;
                    unf_st_q <= unf_d;
                    inv_st_q <= inv_d;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    result_q    <= res_st_q;
                    sign_q      <= sgn_st_q;
                    overflow_q  <= ovf_st_q;
                    underflow_q <= unf_st_q;
                    invalid_q   <= inv_st_q;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign sign      = sign_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign invalid   = invalid_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_t07_fpu_mult.sv
// Directed bench for t07_fpu_mult: hand-computed products, special cases,
// latency, start-while-busy and mid-operation reset.
module tb_t07_fpu_mult;
    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [31:0] inA, inB;
    logic        busy, done, sign, overflow, underflow, invalid;
    logic [31:0] result;
    logic [2:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    t07_fpu_mult dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .inA       (inA),
        .inB       (inB),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .sign      (sign),
        .overflow  (overflow),
        .underflow (underflow),
        .invalid   (invalid),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one start and waits for done; lat counts edges after the accepting edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic busy0);
        @(negedge clk);
        inA   = a;
        inB   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy0 = busy;
        lat   = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input logic [3:0] exp_flags);
        int   lat;
        logic busy0;
        run_op(a, b, lat, busy0);
        check({tag, " latency"}, 32'(lat), 32'd28);
        check({tag, " busy_after_start"}, {31'b0, busy0}, 32'd1);
        check({tag, " result"}, result, exp_res);
        check({tag, " sign/ovf/unf/inv"}, {28'b0, sign, overflow, underflow, invalid},
              {28'b0, exp_flags});
        check({tag, " busy_at_done"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int   ndone;
        logic [31:0] cap;
        nrst  = 1'b0;
        start = 1'b0;
        inA   = '0;
        inB   = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", {26'b0, busy, done, sign, overflow, underflow, invalid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset state", {29'b0, state_dbg}, 32'd0);
        nrst = 1'b1;

        // flags order: {sign, overflow, underflow, invalid}
        op_check("1.5*2", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        op_check("-2*0.5", 32'hC0000000, 32'h3F000000, 32'hBF800000, 4'b1000);
        op_check("round_down", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0000);
        op_check("round_tie_even", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0000);
        op_check("0*inf", 32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b0001);
        op_check("-0*3", 32'h80000000, 32'h40400000, 32'h80000000, 4'b1000);
        op_check("nan*1", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0001);
        op_check("-inf*2", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b1000);
        op_check("overflow", 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0100);
        op_check("underflow", 32'h00800000, 32'h00800000, 32'h00000000, 4'b0010);

        // start during the done cycle is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_cycle_start busy", {31'b0, busy}, 32'd0);
        check("done_cycle_start state", {29'b0, state_dbg}, 32'd0);

        // start while busy is ignored
        @(negedge clk);
        inA   = 32'h3FC00000;
        inB   = 32'h40000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        inA   = 32'hC0000000;
        inB   = 32'h3F000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        cap   = '0;
        repeat (70) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                cap = result;
            end
        end
        check("busy_start done_count", 32'(ndone), 32'd1);
        check("busy_start result", cap, 32'h40400000);
        check("flags cleared no-start hold", {28'b0, sign, overflow, underflow, invalid}, 32'd0);

        // back-to-back: start in the cycle after done
        op_check("b2b_first", 32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000);
        op_check("b2b_second", 32'hBF800000, 32'hBF800000, 32'h3F800000, 4'b0000);

        // reset in the middle of an operation
        @(negedge clk);
        inA   = 32'h3FC00000;
        inB   = 32'h40000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset busy", {31'b0, busy}, 32'd1);
        nrst = 1'b0;
        @(negedge clk);
        check("mid_reset outputs", {26'b0, busy, done, sign, overflow, underflow, invalid}, 32'd0);
        check("mid_reset result", result, 32'd0);
        check("mid_reset state", {29'b0, state_dbg}, 32'd0);
        nrst  = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("mid_reset no_done", 32'(ndone), 32'd0);
        op_check("after_reset", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
